multicycle_control: RTL and testbench

- Main control FSM of the multi-cycle processor.
- Sequences instruction fetch, decode, ALU execute, memory access and register writeback around the shared 3-bit-opcode ALU.
- Drives ALU opcode/operand selects, IR/PC/register-file write enables and the memory request handshake.
- Consumes the ALU updatePC flag to resolve branches.

---
 rtl/multicycle_control.sv | 110 +++++++++++
 tb/tb_multicycle_control.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: main FSM sequencing fetch/decode/execute/memory/writeback with memory timeout fault
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             halt,
  input  logic [31:0]      instr,
  input  logic             memReady,
  input  logic             updatePC,
  output logic             memReq,
  output logic             memWrite,
  output logic             memAddrSel,
  output logic             irWrite,
  output logic [2:0]       aluOpcode,
  output logic             aluSrcB,
  output logic             pcWrite,
  output logic             pcSrc,
  output logic             regWrite,
  output logic             wbSel,
  output logic             busy,
  output logic             fault,
  output logic [CNT_W-1:0] instrCount
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK} state_t;
  localparam logic [2:0] OP_LOAD = 3'd0, OP_STORE = 3'd1, OP_ADD = 3'd4;
  localparam int TW = $clog2(MEM_TIMEOUT);
  state_t r_state, w_next;
  logic [2:0] r_op, r_alu_op;
  logic [TW-1:0] r_to;
  logic [CNT_W-1:0] r_cnt;
  logic r_fault, w_retire, w_timeout, w_enter, w_unused;
  assign w_unused = ^instr[28:0];
  assign busy = r_state != IDLE;
  assign fault = r_fault;
  assign instrCount = r_cnt;
  assign w_enter = (w_next == FETCH || w_next == MEMORY) && w_next != r_state;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_state  <= IDLE;
      r_op     <= '0;
      r_alu_op <= '0;
      r_to     <= '0;
      r_cnt    <= '0;
      r_fault  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == DECODE) r_op <= instr[31:29];
      if (r_state == EXECUTE) r_alu_op <= aluOpcode;
      r_to <= w_enter ? '0 : (memReq && !memReady) ? r_to + 1'b1 : r_to;
      if (w_timeout) r_fault <= 1'b1;
      else if (r_state == IDLE && start) r_fault <= 1'b0;
      if (w_retire) r_cnt <= r_cnt + 1'b1;
    end
  always_comb begin
    w_next     = r_state;
    memReq     = 1'b0;
    memWrite   = 1'b0;
    memAddrSel = 1'b0;
    irWrite    = 1'b0;
    aluOpcode  = r_alu_op;
    aluSrcB    = 1'b0;
    pcWrite    = 1'b0;
    pcSrc      = 1'b0;
    regWrite   = 1'b0;
    wbSel      = 1'b0;
    w_retire   = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      IDLE: w_next = (start && !halt) ? FETCH : IDLE;
      FETCH: begin
        memReq    = 1'b1;
        irWrite   = memReady;
        pcWrite   = memReady;
        w_timeout = !memReady && r_to == TW'(MEM_TIMEOUT - 1);
        w_next    = memReady ? DECODE : w_timeout ? IDLE : FETCH;
      end
      DECODE: w_next = EXECUTE;
      EXECUTE: begin
        aluOpcode = r_op[2:1] == 2'b00 ? OP_ADD : r_op;
        aluSrcB   = r_op[2:1] == 2'b00;
        if (r_op[2:1] == 2'b01) begin
          pcWrite  = updatePC;
          pcSrc    = 1'b1;
          w_retire = 1'b1;
          w_next   = halt ? IDLE : FETCH;
        end else
          w_next = r_op[2] ? WRITEBACK : MEMORY;
      end
      MEMORY: begin
        memReq     = 1'b1;
        memAddrSel = 1'b1;
        memWrite   = r_op == OP_STORE;
        w_timeout  = !memReady && r_to == TW'(MEM_TIMEOUT - 1);
        w_retire   = memReady && r_op == OP_STORE;
        w_next     = !memReady ? (w_timeout ? IDLE : MEMORY) :
                     r_op == OP_STORE ? (halt ? IDLE : FETCH) : WRITEBACK;
      end
      WRITEBACK: begin
        regWrite = 1'b1;
        wbSel    = r_op == OP_LOAD;
        w_retire = 1'b1;
        w_next   = halt ? IDLE : FETCH;
      end
      default: w_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed per-cycle stimulus with a queued-expectation scoreboard
module tb_multicycle_control;
  typedef struct {
    logic [15:0] v;
    logic [15:0] m;
    string       tag;
  } exp_t;
  localparam logic [15:0] M_ALL = 16'hFFFF, M_I = 16'h9EAF, M_F = 16'hFEEF, M_E = 16'h9FAF;
  localparam logic [15:0] M_EB = 16'h9FEF, M_M = 16'hFEAF, M_W = 16'h9EBF;
  logic clk = 1'b0, rstn, start, halt, memReady, updatePC;
  logic [31:0] instr;
  logic memReq, memWrite, memAddrSel, irWrite, aluSrcB, pcWrite, pcSrc, regWrite, wbSel, busy, fault;
  logic [2:0] aluOpcode;
  logic [1:0] instrCount;
  logic [15:0] obs;
  exp_t q[$];
  int n_cmp = 0, n_err = 0;
  logic [1:0] m_cnt = 2'd0;
  logic [2:0] m_alu = 3'd0;
  logic m_fault = 1'b0;
  multicycle_control #(.MEM_TIMEOUT(4), .CNT_W(2)) dut (
    .clk(clk), .rstn(rstn), .start(start), .halt(halt), .instr(instr),
    .memReady(memReady), .updatePC(updatePC), .memReq(memReq), .memWrite(memWrite),
    .memAddrSel(memAddrSel), .irWrite(irWrite), .aluOpcode(aluOpcode), .aluSrcB(aluSrcB),
    .pcWrite(pcWrite), .pcSrc(pcSrc), .regWrite(regWrite), .wbSel(wbSel), .busy(busy),
    .fault(fault), .instrCount(instrCount)
  );
  always #5 clk = ~clk;
  assign obs = {memReq, memWrite, memAddrSel, irWrite, aluOpcode, aluSrcB, pcWrite, pcSrc,
                regWrite, wbSel, busy, fault, instrCount};
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if (((obs ^ e.v) & e.m) != 16'h0) begin
        n_err++;
        $display("FAIL %s: got %h expected %h (mask %h) at %0t", e.tag, obs, e.v, e.m, $time);
      end
    end
  function automatic exp_t e_st(input string t, input bit req, input bit wr, input bit asel,
                                input bit irw, input logic [2:0] alu, input bit srcb, input bit pcw,
                                input bit pcs, input bit rw, input bit wbs, input bit bsy,
                                input logic [15:0] m);
    exp_t e;
    e.v = {req, wr, asel, irw, alu, srcb, pcw, pcs, rw, wbs, bsy, m_fault, m_cnt};
    e.m = m;
    e.tag = t;
    return e;
  endfunction
  task automatic cyc(input bit st, input bit hl, input bit rdy, input bit upd, input exp_t e);
    start = st;
    halt = hl;
    memReady = rdy;
    updatePC = upd;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  task automatic p_idle(input bit st, input bit hl, input string t);
    cyc(st, hl, 1'b1, 1'b0, e_st(t, 0, 0, 0, 0, m_alu, 0, 0, 0, 0, 0, 0, M_I));
    if (st) m_fault = 1'b0;
  endtask
  task automatic p_fetch();
    cyc(0, 0, 1, 0, e_st("fetch", 1, 0, 0, 1, m_alu, 0, 1, 0, 0, 0, 1, M_F));
  endtask
  task automatic p_decode(input bit hl);
    cyc(0, hl, 1, 0, e_st("decode", 0, 0, 0, 0, m_alu, 0, 0, 0, 0, 0, 1, M_I));
  endtask
  task automatic p_exec_mem(input bit hl);
    m_alu = 3'd4;
    cyc(0, hl, 0, 1, e_st("exec_mem", 0, 0, 0, 0, 3'd4, 1, 0, 0, 0, 0, 1, M_E));
  endtask
  task automatic p_wb(input logic [2:0] op, input bit hl);
    cyc(0, hl, 0, 0, e_st("wb", 0, 0, 0, 0, m_alu, 0, 0, 0, 1, op == 3'd0, 1, M_W));
    m_cnt = m_cnt + 1'b1;
  endtask
  task automatic do_instr(input logic [31:0] ins, input int mwait, input bit upd, input bit hl);
    logic [2:0] op;
    op = ins[31:29];
    instr = ins;
    p_fetch();
    p_decode(hl);
    if (op[2:1] == 2'b01) begin
      m_alu = op;
      cyc(0, hl, 0, upd, e_st("exec_br", 0, 0, 0, 0, op, 0, upd, 1, 0, 0, 1, M_EB));
      m_cnt = m_cnt + 1'b1;
    end else if (op[2]) begin
      m_alu = op;
      cyc(0, hl, 0, 1, e_st("exec_alu", 0, 0, 0, 0, op, 0, 0, 0, 0, 0, 1, M_E));
      p_wb(op, hl);
    end else begin
      p_exec_mem(hl);
      for (int i = 0; i < mwait; i++)
        cyc(0, hl, 0, 0, e_st("mem_wait", 1, op[0], 1, 0, m_alu, 0, 0, 0, 0, 0, 1, M_M));
      cyc(0, hl, 1, 0, e_st("mem_done", 1, op[0], 1, 0, m_alu, 0, 0, 0, 0, 0, 1, M_M));
      if (op[0]) m_cnt = m_cnt + 1'b1;
      else p_wb(op, hl);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    rstn = 1'b0;
    start = 1'b0;
    halt = 1'b0;
    instr = 32'h0;
    memReady = 1'b0;
    updatePC = 1'b0;
    @(posedge clk);
    #1;
    cyc(1, 0, 1, 1, e_st("reset", 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, M_ALL));
    rstn = 1'b1;
    p_idle(0, 0, "idle");
    p_idle(1, 0, "start");
    do_instr(32'h8000_0000, 0, 0, 0);
    instr = 32'h0000_1234;
    p_fetch();
    p_decode(0);
    p_exec_mem(0);
    cyc(0, 0, 0, 0, e_st("mem_wait", 1, 0, 1, 0, m_alu, 0, 0, 0, 0, 0, 1, M_M));
    rstn = 1'b0;
    m_cnt = 2'd0;
    m_alu = 3'd0;
    m_fault = 1'b0;
    cyc(0, 0, 1, 0, e_st("reset_mid_load", 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, M_ALL));
    rstn = 1'b1;
    p_idle(0, 0, "post_reset");
    p_idle(1, 0, "start2");
    do_instr(32'h4000_0000, 0, 1, 0);
    do_instr(32'h6000_0000, 0, 0, 0);
    do_instr(32'h0000_1234, 3, 0, 0);
    do_instr(32'h2000_0000, 0, 0, 0);
    instr = 32'h8000_0000;
    for (int i = 0; i < 4; i++)
      cyc(0, 0, 0, 0, e_st("fetch_wait", 1, 0, 0, 0, m_alu, 0, 0, 0, 0, 0, 1, M_F));
    m_fault = 1'b1;
    p_idle(0, 0, "faulted");
    p_idle(1, 1, "start_halt");
    p_idle(0, 0, "fault_cleared");
    p_idle(1, 0, "start3");
    do_instr(32'hA000_0000, 0, 0, 1);
    p_idle(0, 0, "halted");
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
